cache_line_writeback: RTL and testbench

Writeback engine for the data cache: when the cache controller evicts a dirty line, this block reads the line out of the line storage one word at a time and sends it to memory as a single AXI4 INCR write burst. It then waits for the write response and reports completion to the controller. It sits between the cache controller and line storage on one side and the AXI write channels (AW/W/B) on the other. It is the read-side counterpart of the line storage's write/refill port.

---
 rtl/cache_line_writeback.sv | 159 +++++++++++++++
 tb/tb_cache_line_writeback.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_writeback.sv
// Dirty-line writeback engine: drains one cache line from line storage as a
// single AXI4 INCR write burst and reports the B response to the controller.
module cache_line_writeback #(
    parameter int unsigned CACHE_LINE_WIDTH = 6,
    parameter int unsigned TAG_WIDTH        = 18,
    parameter int unsigned INDEX_WIDTH      = 8,
    parameter logic [3:0]  AXI_ID           = 4'd1
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        wb_req,
    input  logic [TAG_WIDTH-1:0]        wb_tag,
    input  logic [INDEX_WIDTH-1:0]      wb_index,
    output logic                        wb_ready,
    output logic                        wb_done,
    output logic                        wb_error,

    output logic [CACHE_LINE_WIDTH-3:0] line_rd_off,
    input  logic [31:0]                 line_rd_data,

    output logic [3:0]                  awid,
    output logic [31:0]                 awaddr,
    output logic [7:0]                  awlen,
    output logic [2:0]                  awsize,
    output logic [1:0]                  awburst,
    output logic                        awvalid,
    input  logic                        awready,

    output logic [31:0]                 wdata,
    output logic [3:0]                  wstrb,
    output logic                        wlast,
    output logic                        wvalid,
    input  logic                        wready,

    input  logic [3:0]                  bid,
    input  logic [1:0]                  bresp,
    input  logic                        bvalid,
    output logic                        bready
);

    localparam int unsigned OFF_W     = CACHE_LINE_WIDTH - 2;
    localparam int unsigned NUM_WORDS = 1 << OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(NUM_WORDS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]             state_q,  state_nxt;
    logic [OFF_W-1:0]       cnt_q,    cnt_nxt;
    logic [TAG_WIDTH-1:0]   tag_q,    tag_nxt;
    logic [INDEX_WIDTH-1:0] index_q,  index_nxt;

    logic ready_nxt;
    logic done_nxt;
    logic error_nxt;
    logic awvalid_nxt;
    logic wvalid_nxt;
    logic wlast_nxt;
    logic bready_nxt;

    // bid and the low bresp bit carry nothing this engine acts on
    logic unused_inputs;
    assign unused_inputs = ^{bid, bresp[0]};

    // Constant burst shape and address built from the latched line identity
    assign awid    = AXI_ID;
    assign awaddr  = {tag_q, index_q, CACHE_LINE_WIDTH'(0)};
    assign awlen   = 8'(NUM_WORDS - 1);
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign wstrb   = 4'hF;

    // Storage read port follows the beat counter; data is passed straight through
    assign line_rd_off = cnt_q;
    assign wdata       = line_rd_data;

    // Next-state, beat counter and registered-output decode
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        tag_nxt   = tag_q;
        index_nxt = index_q;
        done_nxt  = 1'b0;
        error_nxt = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wb_req) begin
                    tag_nxt   = wb_tag;
                    index_nxt = wb_index;
                    cnt_nxt   = '0;
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (awready) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (wready) begin
                    cnt_nxt = cnt_q + OFF_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_nxt = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (bvalid) begin
                    done_nxt  = 1'b1;
                    error_nxt = bresp[1];
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        ready_nxt   = (state_nxt == ST_IDLE);
        awvalid_nxt = (state_nxt == ST_ADDR);
        wvalid_nxt  = (state_nxt == ST_DATA);
        bready_nxt  = (state_nxt == ST_RESP);
        wlast_nxt   = (state_nxt == ST_DATA) && (cnt_nxt == LAST_BEAT);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            tag_q    <= '0;
            index_q  <= '0;
            wb_ready <= 1'b1;
            wb_done  <= 1'b0;
            wb_error <= 1'b0;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            wlast    <= 1'b0;
            bready   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            tag_q    <= tag_nxt;
            index_q  <= index_nxt;
            wb_ready <= ready_nxt;
            wb_done  <= done_nxt;
            wb_error <= error_nxt;
            awvalid  <= awvalid_nxt;
            wvalid   <= wvalid_nxt;
            wlast    <= wlast_nxt;
            bready   <= bready_nxt;
        end
    end

endmodule

// File: tb/tb_cache_line_writeback.sv
// Randomized bench for cache_line_writeback against a transaction-level model
// (line snapshot, beat index, AXI phase flags) updated once per clock.
module tb_cache_line_writeback;

    localparam int unsigned CLW = 6;
    localparam int unsigned TW  = 18;
    localparam int unsigned IW  = 8;
    localparam int unsigned OW  = CLW - 2;
    localparam int unsigned N   = 1 << OW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wb_req = 1'b0;
    logic [TW-1:0] wb_tag = '0;
    logic [IW-1:0] wb_index = '0;
    logic          wb_ready, wb_done, wb_error;
    logic [OW-1:0] line_rd_off;
    logic [31:0]   line_rd_data;
    logic [3:0]    awid;
    logic [31:0]   awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awvalid;
    logic          awready = 1'b0;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wlast, wvalid;
    logic          wready = 1'b0;
    logic [3:0]    bid = 4'h0;
    logic [1:0]    bresp = 2'b00;
    logic          bvalid = 1'b0;
    logic          bready;

    logic [31:0] mem [N];
    assign line_rd_data = mem[line_rd_off];

    always #5 clk = ~clk;

    cache_line_writeback #(
        .CACHE_LINE_WIDTH(CLW),
        .TAG_WIDTH(TW),
        .INDEX_WIDTH(IW),
        .AXI_ID(4'd1)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_req(wb_req), .wb_tag(wb_tag), .wb_index(wb_index),
        .wb_ready(wb_ready), .wb_done(wb_done), .wb_error(wb_error),
        .line_rd_off(line_rd_off), .line_rd_data(line_rd_data),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: one outstanding writeback described by its phase flags
    bit          busy = 0, aw_done = 0, done_exp = 0, err_exp = 0, lat_on = 0;
    int          beats = 0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_data [N];
    int          cyc = 0, acc_cyc = 0, naccept = 0, ndone = 0, acc_target = 0;
    int          aw_wait = 0, b_wait = 0, pidx = 0;
    int          mode = 0;
    bit          hold = 0, rst_done = 0, rst_pulse = 0;
    bit          wpat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic step();
        bit w_phase;
        @(negedge clk);
        cyc++;
        w_phase = busy && aw_done && (beats < N);

        // Compare DUT state against the model
        check("wb_ready", 32'(wb_ready), 32'(!busy));
        check("awvalid",  32'(awvalid),  32'(busy && !aw_done));
        check("wvalid",   32'(wvalid),   32'(w_phase));
        check("bready",   32'(bready),   32'(busy && beats == N));
        check("wb_done",  32'(wb_done),  32'(done_exp));
        check("wlast",    32'(wlast),    32'(w_phase && beats == N - 1));
        if (done_exp) check("wb_error", 32'(wb_error), 32'(err_exp));
        if (done_exp && lat_on) check("latency", 32'(cyc - acc_cyc), 32'(N + 3));
        if (busy && !aw_done) check("awaddr", awaddr, exp_addr);
        if (w_phase) begin
            check("wdata",       wdata,              exp_data[beats]);
            check("line_rd_off", 32'(line_rd_off),   32'(beats));
        end else begin
            check("line_rd_off_rest", 32'(line_rd_off), 32'(0));
        end

        // Drive the next cycle's inputs
        if (rst_pulse) begin
            rst = 1'b1;
            rst_pulse = 0;
        end
        wb_tag   = TW'($urandom);
        wb_index = IW'($urandom);
        if (mode == 0 && !busy) begin
            wb_tag   = 18'h2_A5A5;
            wb_index = 8'h3C;
        end
        if (!busy) begin
            for (int i = 0; i < N; i++) mem[i] = $urandom;
        end
        awready = 1'b1;
        wready  = 1'b1;
        bvalid  = 1'b1;
        bresp   = 2'b00;
        case (mode)
            1: begin
                awready = (aw_wait >= 3);
                wready  = wpat[pidx % 4];
            end
            2: begin
                bvalid = (b_wait >= 5);
                bresp  = 2'b10;
            end
            5: begin
                awready = ($urandom_range(0, 2) != 0);
                wready  = ($urandom_range(0, 2) != 0);
                bvalid  = ($urandom_range(0, 1) != 0);
                bresp   = 2'($urandom);
            end
            default: ;
        endcase
        bid = 4'($urandom);
        if (mode == 5) wb_req = ($urandom_range(0, 3) == 0) && (naccept < acc_target);
        else           wb_req = (hold || !busy) && (naccept < acc_target);

        // Asynchronous reset in the middle of the data phase
        if (mode == 4 && !rst_done && w_phase && beats == 7) begin
            rst = 1'b0;
            #1;
            check("rst_awvalid",     32'(awvalid),     32'(0));
            check("rst_wvalid",      32'(wvalid),      32'(0));
            check("rst_bready",      32'(bready),      32'(0));
            check("rst_wb_ready",    32'(wb_ready),    32'(1));
            check("rst_line_rd_off", 32'(line_rd_off), 32'(0));
            busy = 0;
            done_exp = 0;
            rst_done = 1;
            rst_pulse = 1;
            return;
        end

        // Advance the model across the coming clock edge
        if (rst) begin
            done_exp = 0;
            if (!busy) begin
                if (wb_req) begin
                    busy = 1; aw_done = 0; beats = 0;
                    aw_wait = 0; b_wait = 0; pidx = 0;
                    exp_addr = {wb_tag, wb_index, 6'b0};
                    for (int i = 0; i < N; i++) exp_data[i] = mem[i];
                    acc_cyc = cyc;
                    lat_on = (mode == 0);
                    naccept++;
                end
            end else if (!aw_done) begin
                if (awready) begin
                    aw_done = 1;
                    check("awlen",   32'(awlen),   32'(N - 1));
                    check("awsize",  32'(awsize),  32'(2));
                    check("awburst", 32'(awburst), 32'(1));
                    check("awid",    32'(awid),    32'(1));
                    check("wstrb",   32'(wstrb),   32'hF);
                    if (mode == 0) check("awaddr_const", awaddr, 32'hA969_4F00);
                end else begin
                    aw_wait++;
                end
            end else if (beats < N) begin
                pidx++;
                if (wready) beats++;
            end else begin
                if (bvalid) begin
                    done_exp = 1;
                    err_exp = bresp[1];
                    busy = 0;
                    ndone++;
                end else begin
                    b_wait++;
                end
            end
        end
    endtask

    task automatic run(input int m, input int ntx, input bit h);
        int budget = 0;
        mode = m;
        hold = h;
        rst_done = 0;
        acc_target = naccept + ntx;
        while (!(naccept >= acc_target && !busy) && budget < 4000) begin
            step();
            budget++;
        end
        check("budget", 32'(budget < 4000), 32'(1));
    endtask

    initial begin
        for (int i = 0; i < N; i++) mem[i] = '0;
        for (int i = 0; i < N; i++) exp_data[i] = '0;
        step();
        rst = 1'b1;
        run(0, 1, 0);   // directed address, full-rate burst, latency
        run(1, 2, 0);   // AW delay and W backpressure
        run(2, 1, 0);   // delayed error response
        run(3, 2, 1);   // request held high, back-to-back acceptance
        run(4, 2, 0);   // reset at beat 7, then a clean burst
        run(5, 40, 0);  // randomized traffic
        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
